// File: rtl/flac_pkg.sv
// Shared FLAC residual definitions: state encodings, coding-method codes,
// fixed widths and the zigzag unfold used to rebuild signed residuals.
package flac_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ORDER_W  = 4;

    localparam logic [1:0] RICE4 = 2'b00;
    localparam logic [1:0] RICE5 = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_METHOD,
        S_ORDER,
        S_CHECK,
        S_DECODE,
        S_LAST,
        S_FIN,
        S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        D_PARAM,
        D_UNARY,
        D_LSB
    } dec_state_t;

    // Even codes map to non-negative values, odd codes to negative ones.
    function automatic logic [SAMPLE_W-1:0] zigzag_decode(input logic [SAMPLE_W-1:0] u);
        return u[0] ? ~(u >> 1) : (u >> 1);
    endfunction

endpackage

// File: rtl/residual_sequencer_rice_decode.sv
// Partitioned Rice decoder: 4-bit parameter per partition, then per sample a
// unary quotient (zeros ended by a one) followed by param LSBs.
module rice_decode
    import flac_pkg::*;
(
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iData,
    input  logic [SAMPLE_W-1:0] iBlockSize,
    input  logic [ORDER_W-1:0]  iPredictorOrder,
    input  logic [ORDER_W-1:0]  iPartitionOrder,
    output logic                oDone,
    output logic [SAMPLE_W-1:0] oMsb,
    output logic [SAMPLE_W-1:0] oLsb,
    output logic [ORDER_W-1:0]  oRiceParam
);

    dec_state_t          state, state_nxt;
    logic [ORDER_W-1:0]  param, bit_cnt;
    logic [SAMPLE_W-1:0] msb_acc, lsb_acc, part_left, part_size;
    logic                sample_end;

    assign part_size = iBlockSize >> iPartitionOrder;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        sample_end = 1'b0;
        state_nxt  = state;
        if (iEn) begin
            case (state)
                D_PARAM: if (bit_cnt == 4'd3) state_nxt = D_UNARY;
                D_UNARY: if (iData) begin
                    if (param == '0) sample_end = 1'b1;
                    else             state_nxt  = D_LSB;
                end
                D_LSB:   if (bit_cnt == param - 4'd1) sample_end = 1'b1;
                default: state_nxt = D_PARAM;
            endcase
            if (sample_end) state_nxt = (part_left == 16'd1) ? D_PARAM : D_UNARY;
        end
    end

    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (iRst) begin
            state      <= D_PARAM;
            param      <= '0;
            bit_cnt    <= '0;
            msb_acc    <= '0;
            lsb_acc    <= '0;
            part_left  <= part_size - SAMPLE_W'(iPredictorOrder);
            oDone      <= 1'b0;
            oMsb       <= '0;
            oLsb       <= '0;
            oRiceParam <= '0;
        end else begin
            state <= state_nxt;
            oDone <= sample_end;
            if (iEn) begin
                case (state)
                    D_PARAM: begin
                        param   <= {param[2:0], iData};
                        bit_cnt <= (bit_cnt == 4'd3) ? '0 : bit_cnt + 4'd1;
                    end
                    D_UNARY: if (!iData) msb_acc <= msb_acc + 16'd1;
                    D_LSB: begin
                        lsb_acc <= {lsb_acc[14:0], iData};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
            // Outputs are captured here so they stay stable while the next sample starts.
            if (sample_end) begin
                oMsb       <= msb_acc;
                oLsb       <= (state == D_LSB) ? {lsb_acc[14:0], iData} : '0;
                oRiceParam <= param;
                msb_acc    <= '0;
                lsb_acc    <= '0;
                bit_cnt    <= '0;
                part_left  <= (part_left == 16'd1) ? part_size : part_left - 16'd1;
            end
        end
    end

endmodule

// File: rtl/residual_sequencer.sv
// Residual sequencer for one FLAC subframe: parses the residual header, drives
// the Rice decoder, counts samples and emits zigzag-decoded residuals.
module residual_sequencer
    import flac_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [15:0] iBlockSize,
    input  logic [3:0]  iPredictorOrder,
    input  logic        iData,
    input  logic        iValid,
    output logic        oReady,
    output logic [15:0] oResidual,
    output logic        oValid,
    output logic        oDone,
    output logic        oError,
    output logic        oBusy
);

    seq_state_t  state, state_nxt;
    logic [1:0]  method, hdr_cnt;
    logic [3:0]  porder, pred_order;
    logic [15:0] block_size, total, count;
    logic        stall, accept, hdr_bad, in_decode;
    logic        dec_rst, dec_en, dec_done;
    logic [15:0] dec_msb, dec_lsb;
    logic [3:0]  dec_param;

    assign in_decode = (state == S_DECODE) || (state == S_LAST);
    assign oReady    = (state == S_METHOD) || (state == S_ORDER) || (state == S_DECODE)
                    || ((state == S_LAST) && !stall);
    assign oBusy     = (state != S_IDLE);
    assign accept    = iValid & oReady;
    assign dec_rst   = iRst | ~in_decode;
    assign dec_en    = accept & in_decode;

    assign hdr_bad = (method != RICE4)
                  || (block_size <= 16'(pred_order))
                  || ((porder != '0) && ((block_size & ((16'd1 << porder) - 16'd1)) != '0))
                  || ((porder != '0) && ((block_size >> porder) <= 16'(pred_order)));

    rice_decode u_rice (
        .iClk            (iClk),
        .iRst            (dec_rst),
        .iEn             (dec_en),
        .iData           (iData),
        .iBlockSize      (block_size),
        .iPredictorOrder (pred_order),
        .iPartitionOrder (porder),
        .oDone           (dec_done),
        .oMsb            (dec_msb),
        .oLsb            (dec_lsb),
        .oRiceParam      (dec_param)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (iStart) state_nxt = S_METHOD;
            S_METHOD: if (accept && hdr_cnt == 2'd1) state_nxt = S_ORDER;
            S_ORDER:  if (accept && hdr_cnt == 2'd3) state_nxt = S_CHECK;
            S_CHECK: begin
                if (hdr_bad)                                          state_nxt = S_ERR;
                else if (block_size - 16'(pred_order) == 16'd1)      state_nxt = S_LAST;
                else                                                  state_nxt = S_DECODE;
            end
            S_DECODE: if (dec_done && (count + 16'd1 == total - 16'd1)) state_nxt = S_LAST;
            S_LAST:   if (stall && dec_done) state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            S_ERR:    if (iStart) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            method     <= '0;
            hdr_cnt    <= '0;
            porder     <= '0;
            pred_order <= '0;
            block_size <= '0;
            total      <= '0;
            count      <= '0;
            stall      <= 1'b0;
            oResidual  <= '0;
            oValid     <= 1'b0;
            oDone      <= 1'b0;
            oError     <= 1'b0;
        end else begin
            oValid <= dec_done;
            oDone  <= (state == S_FIN);
            if (dec_done) oResidual <= zigzag_decode((dec_msb << dec_param) | dec_lsb);
            case (state)
                S_IDLE: if (iStart) begin
                    block_size <= iBlockSize;
                    pred_order <= iPredictorOrder;
                    hdr_cnt    <= '0;
                end
                S_METHOD: if (accept) begin
                    method  <= {method[0], iData};
                    hdr_cnt <= (hdr_cnt == 2'd1) ? 2'd0 : hdr_cnt + 2'd1;
                end
                S_ORDER: if (accept) begin
                    porder  <= {porder[2:0], iData};
                    hdr_cnt <= hdr_cnt + 2'd1;
                end
                S_CHECK: begin
                    total  <= block_size - 16'(pred_order);
                    count  <= '0;
                    stall  <= 1'b1;
                    oError <= hdr_bad;
                end
                S_DECODE: begin
                    if (dec_done) count <= count + 16'd1;
                    // LAST opens with a stall so a bit taken on the entry edge is never followed by another.
                    stall <= 1'b1;
                end
                S_LAST: begin
                    if (stall)       stall <= 1'b0;
                    else if (accept) stall <= 1'b1;
                end
                S_ERR: if (iStart) oError <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_residual_sequencer.sv
// Bench for residual_sequencer: a Rice encoder model builds each bitstream and
// the signed residuals it must decode back to.
module tb_residual_sequencer;

    logic        clk = 1'b0;
    logic        iRst, iStart, iData, iValid;
    logic [15:0] iBlockSize;
    logic [3:0]  iPredictorOrder;
    logic        oReady, oValid, oDone, oError, oBusy;
    logic [15:0] oResidual;

    int n_vec = 0;
    int n_miss = 0;
    int done_seen = 0;
    int extra = 0;
    bit bit_q[$];
    int exp_q[$];
    int par_q[$];
    int res_q[$];

    always #5 clk = ~clk;

    residual_sequencer dut (
        .iClk            (clk),
        .iRst            (iRst),
        .iStart          (iStart),
        .iBlockSize      (iBlockSize),
        .iPredictorOrder (iPredictorOrder),
        .iData           (iData),
        .iValid          (iValid),
        .oReady          (oReady),
        .oResidual       (oResidual),
        .oValid          (oValid),
        .oDone           (oDone),
        .oError          (oError),
        .oBusy           (oBusy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic int zz(input int r);
        return (r >= 0) ? 2 * r : -2 * r - 1;
    endfunction

    // Encoder model: header, then per partition a parameter and its Rice-coded samples.
    task automatic build(input int block, input int pred, input int porder,
                         input int method, input bit with_body);
        int idx, k, n, u;
        bit_q.delete();
        exp_q.delete();
        for (int b = 1; b >= 0; b--) bit_q.push_back(bit'((method >> b) & 1));
        for (int b = 3; b >= 0; b--) bit_q.push_back(bit'((porder >> b) & 1));
        if (with_body) begin
            idx = 0;
            for (int p = 0; p < (1 << porder); p++) begin
                k = par_q[p];
                n = (block >> porder) - ((p == 0) ? pred : 0);
                for (int b = 3; b >= 0; b--) bit_q.push_back(bit'((k >> b) & 1));
                for (int s = 0; s < n; s++) begin
                    u = zz(res_q[idx]);
                    for (int z = 0; z < (u >> k); z++) bit_q.push_back(1'b0);
                    bit_q.push_back(1'b1);
                    for (int b = k - 1; b >= 0; b--) bit_q.push_back(bit'((u >> b) & 1));
                    exp_q.push_back(res_q[idx]);
                    idx++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (oValid) begin
            check("residual_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("residual", 32'($signed(oResidual)), 32'(exp_q.pop_front()));
        end
        if (oDone) done_seen++;
    end

    task automatic start(input int block, input int pred);
        iStart          = 1'b1;
        iBlockSize      = 16'(block);
        iPredictorOrder = 4'(pred);
        @(posedge clk); #1;
        iStart = 1'b0;
    endtask

    task automatic drive_stream(input bit rand_valid, input bit wait_done,
                                input int budget, input bit allow_timeout);
        int n;
        bit fin, just_emptied;
        n = 0;
        fin = 1'b0;
        just_emptied = 1'b0;
        while (!fin && n < budget) begin
            if (bit_q.size() > 0) begin
                iValid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                iData  = bit_q[0];
            end else begin
                iValid = 1'b1;
                iData  = 1'b1;
            end
            @(negedge clk); #1;
            if (just_emptied) begin
                check("ready_low_after_last", 32'(oReady), 32'd0);
                just_emptied = 1'b0;
            end
            if (iValid && oReady) begin
                if (bit_q.size() > 0) begin
                    void'(bit_q.pop_front());
                    if (bit_q.size() == 0 && wait_done) just_emptied = 1'b1;
                end else begin
                    extra++;
                end
            end
            fin = wait_done ? (done_seen > 0) : (bit_q.size() == 0);
            @(posedge clk); #1;
            n++;
        end
        if (!allow_timeout) check("stream_completed", 32'(fin), 32'd1);
    endtask

    task automatic run_ok(input string name, input int block, input int pred,
                          input int porder, input bit rand_valid);
        build(block, pred, porder, 0, 1'b1);
        done_seen = 0;
        extra = 0;
        start(block, pred);
        drive_stream(rand_valid, 1'b1, 600, 1'b0);
        iValid = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_all_residuals"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_once"}, 32'(done_seen), 32'd1);
        check({name, "_no_overread"}, 32'(extra), 32'd0);
        check({name, "_idle"}, 32'(oBusy), 32'd0);
    endtask

    task automatic run_err(input string name, input int block, input int pred,
                           input int method, input int porder);
        build(block, pred, porder, method, 1'b0);
        done_seen = 0;
        start(block, pred);
        drive_stream(1'b0, 1'b0, 40, 1'b0);
        iValid = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_error"}, 32'(oError), 32'd1);
        check({name, "_ready_low"}, 32'(oReady), 32'd0);
        check({name, "_busy"}, 32'(oBusy), 32'd1);
        start(block, pred);
        @(negedge clk);
        check({name, "_error_cleared"}, 32'(oError), 32'd0);
        check({name, "_back_idle"}, 32'(oBusy), 32'd0);
        check({name, "_no_done"}, 32'(done_seen), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        iRst = 1'b1;
        iStart = 1'b0;
        iData = 1'b0;
        iValid = 1'b0;
        iBlockSize = '0;
        iPredictorOrder = '0;
        repeat (3) @(posedge clk);
        #1 iRst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_error", 32'(oError), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ready", 32'(oReady), 32'd0);
        check("rst_residual", 32'(oResidual), 32'd0);

        // Pin the encoder model against hand-computed values.
        check("zz_neg2", 32'(zz(-2)), 32'd3);
        check("zz_pos3", 32'(zz(3)), 32'd6);
        check("zz_neg1", 32'(zz(-1)), 32'd1);

        // Block 16, pred 2, one partition, param 1, u = 0,1,2,3 repeating.
        par_q = '{1};
        res_q.delete();
        for (int i = 0; i < 14; i++) begin
            case (i % 4)
                0: res_q.push_back(0);
                1: res_q.push_back(-1);
                2: res_q.push_back(1);
                default: res_q.push_back(-2);
            endcase
        end
        build(16, 2, 0, 0, 1'b1);
        check("t1_stream_len", 32'(bit_q.size()), 32'd44);
        run_ok("t1", 16, 2, 0, 1'b0);

        // Two partitions (6 then 8 samples) with params 0 and 3.
        par_q = '{0, 3};
        res_q = '{0, -1, 1, -2, 2, -3, 5, -6, 7, -8, 0, 1, -1, 12};
        run_ok("t2", 16, 2, 1, 1'b0);

        // Illegal headers.
        run_err("t3_method1", 16, 2, 1, 0);
        run_err("t4_part_small", 16, 4, 0, 3);
        run_err("t4_indivisible", 20, 2, 0, 3);
        run_err("t4_block_le_pred", 2, 2, 0, 0);

        // Same stream as the first case with iValid toggled randomly.
        par_q = '{1};
        res_q.delete();
        for (int i = 0; i < 14; i++) begin
            case (i % 4)
                0: res_q.push_back(0);
                1: res_q.push_back(-1);
                2: res_q.push_back(1);
                default: res_q.push_back(-2);
            endcase
        end
        run_ok("t5", 16, 2, 0, 1'b1);

        // Reset in the middle of decoding.
        build(16, 2, 0, 0, 1'b1);
        done_seen = 0;
        start(16, 2);
        drive_stream(1'b0, 1'b1, 20, 1'b1);
        iRst = 1'b1;
        iValid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        bit_q.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(oValid), 32'd0);
        check("mid_rst_done", 32'(oDone), 32'd0);
        check("mid_rst_busy", 32'(oBusy), 32'd0);
        check("mid_rst_ready", 32'(oReady), 32'd0);
        check("mid_rst_residual", 32'(oResidual), 32'd0);
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        iRst = 1'b0;
        @(posedge clk); #1;

        // Single-sample residual: block 2, pred 1, param 0, u = 6.
        par_q = '{0};
        res_q = '{3};
        build(2, 1, 0, 0, 1'b1);
        check("t7_stream_len", 32'(bit_q.size()), 32'd17);
        run_ok("t7", 2, 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/residual_sequencer.md
Name: residual_sequencer

Overview:
- Controls residual decoding for one FLAC subframe. Parses the 2-bit residual coding method and the 4-bit partition order from the serial bitstream.
- Configures and resets the existing riceDecode block, then gates bits into it with a valid/ready handshake.
- Counts decoded samples and stops exactly at the last bit of the residual.
- Reconstructs each signed residual by zigzag-decoding the MSB/LSB/parameter triple, and sits between the subframe header parser and the LPC/fixed predictor.

Parameters:
- None. All widths are fixed: 16-bit samples and block size, 4-bit predictor order, partition order and Rice parameter.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous reset, active-high.
- iStart  in  1  one-cycle pulse in IDLE. Latches iBlockSize and iPredictorOrder; ignored in other states.
- iBlockSize  in  16  frame block size.
- iPredictorOrder  in  4  subframe predictor order (warm-up samples excluded from the residual).
- iData  in  1  serial bitstream bit, MSB-first.
- iValid  in  1  iData is valid.
- oReady  out  1  bit consumed on this edge when iValid & oReady.
- oResidual  out  16  signed reconstructed residual.
- oValid  out  1  one-cycle strobe qualifying oResidual.
- oDone  out  1  one-cycle pulse when the last residual has been emitted.
- oError  out  1  sticky until iRst or the next iStart. Set on an unsupported or illegal header.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; decoder held in reset.
- States:
  - IDLE -> METHOD on iStart.
  - METHOD: accepts 2 bits into method.
  - ORDER: accepts 4 bits into porder.
  - CHECK: 1 cycle, no bits consumed.
  - DECODE.
  - LAST.
  - FIN: 1 cycle; pulses oDone -> IDLE.
  - ERR: holds oError, oReady=0; -> IDLE on iStart.
- oReady = iValid-independent; high in METHOD, ORDER, DECODE, and on alternate cycles in LAST (see below). Low in all other states.
- Decoder wiring:
  - Decoder iRst = iRst | (state not DECODE/LAST).
  - Decoder iPartitionOrder = porder register, stable from CHECK onward, so the decoder's reset-time size computation sees final values.
  - Decoder iEn = iValid & oReady & (state is DECODE or LAST).
- CHECK errors (-> ERR):
  - method != 0. Method 1 (5-bit parameters) and reserved codes are not supported.
  - iBlockSize <= predictor order.
  - porder > 0 and blocksize not divisible by 2^porder.
  - porder > 0 and (blocksize >> porder) <= predictor order.
- CHECK otherwise: total = blocksize - predictor order; count = 0; -> DECODE, or LAST if total == 1.
- Counting: each decoder done pulse increments count. When the pulse raises count to total-1 -> LAST.
- LAST handshake: the final sample must not over-read. The decoder done pulse appears the cycle after its last bit is consumed, so in LAST:
  - Accept one bit, then hold oReady=0 for the next cycle and sample decoder done.
  - Done seen -> FIN.
  - Not seen -> accept next bit.
  - Guarantees zero bits consumed past the residual.
- Reconstruction, on decoder done:
  - u = (MSB << RiceParam) | LSB, computed in 16 bits; overflow is truncated.
  - oResidual = u[0] ? ~(u >> 1) : (u >> 1). This is the two's-complement of -(u>>1)-1.
  - Registered: oValid rises one cycle after decoder done; latency 1.
- Rice parameter 15 (escape): not supported. Decoding proceeds, no detection required; the integrator guarantees the encoder does not emit it.
- iStart outside IDLE/ERR: ignored.
- iRst mid-operation: immediate return to IDLE, decoder reset, no oDone.
- iValid low: no state change, no bit consumed; the LAST stall cycle still elapses.

Decomposition:
- Shared package flac_pkg:
  - State encoding constants.
  - Coding-method constants (RICE4=2'b00, RICE5=2'b01).
  - Width constants (SAMPLE_W=16, ORDER_W=4).
- One sub-module instance: riceDecode (existing).
- Zigzag unfold is a small combinational function kept inline or in flac_pkg as zigzag_decode.

Test Plan:
- Block 16, pred order 2, bits 00 0000, param 0001, residuals u=0,1,2,3 repeated -> 14 oValid with oResidual 0,-1,1,-2,...; oDone once; oReady low immediately after the final bit and no further bits taken.
- Block 16, pred 2, porder 1 (partitions 6 and 8), param 0 then 0011 -> 14 residuals; second partition parameter applied; count wraps correctly.
- Method bits 01 -> oError=1, state ERR, oReady=0, no oValid; next iStart clears oError.
- Block 16, pred 4, porder 3 (size 2 <= 4) -> oError.
- iValid toggled randomly mid-residual with the same stream as test 1 -> identical oResidual sequence.
- iRst asserted mid-DECODE -> outputs zero next cycle; a fresh iStart decodes correctly.
- Block 2, pred 1, total 1, param 0, unary 0000001 (u=6) -> oResidual=3; oDone one cycle later.
